// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, funct codes, sequencer state and mul/div kinds
package alu_pkg;
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_XOR     = 4'b0011;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_NOR     = 4'b1100;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    // ordered to match funct[1:0] of the mul/div group
    typedef enum logic [1:0] {MULT, MULTU, DIV, DIVU} md_kind_t;
endpackage

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: execute-stage control bus between pipeline and ALU control sequencer
interface alu_ctrl_seq_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       op_alu;
    logic [5:0]       funct;
    logic             valid;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [3:0]       op;
    logic             illegal;
    logic             stall;
    logic [WIDTH-1:0] md_rd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             md_done;
    modport master (
        output op_alu, funct, valid, rs_val, rt_val,
        input  op, illegal, stall, md_rd, hi, lo, md_done
    );
    modport slave (
        input  op_alu, funct, valid, rs_val, rt_val,
        output op, illegal, stall, md_rd, hi, lo, md_done
    );
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-step shift-add multiplier / restoring divider with sign fix-up
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             last,
    input  md_kind_t         kind,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             res_vld
);
    logic [WIDTH-1:0]   acc, q, m, acc_n, q_n, q_fix, r_fix;
    logic [WIDTH:0]     add, rem, diff;
    logic [2*WIDTH-1:0] prod, p_fix;
    logic               sgn, is_div, neg_q, neg_r, dz;
    assign sgn  = kind == MULT || kind == DIV;
    assign add  = q[0] ? {1'b0, acc} + {1'b0, m} : {1'b0, acc};
    assign rem  = {acc, q[WIDTH-1]};
    assign diff = rem - {1'b0, m};
    assign acc_n = is_div ? (diff[WIDTH] ? rem[WIDTH-1:0] : diff[WIDTH-1:0]) : add[WIDTH:1];
    assign q_n   = is_div ? {q[WIDTH-2:0], ~diff[WIDTH]} : {add[0], q[WIDTH-1:1]};
    assign prod  = {acc_n, q_n};
    assign p_fix = neg_q ? -prod : prod;
    // divide by zero: all-ones quotient; remainder sign fix restores the raw dividend
    assign q_fix = dz ? '1 : (neg_q ? -q_n : q_n);
    assign r_fix = neg_r ? -acc_n : acc_n;
    assign res_hi  = is_div ? r_fix : p_fix[2*WIDTH-1:WIDTH];
    assign res_lo  = is_div ? q_fix : p_fix[WIDTH-1:0];
    assign res_vld = step && last;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {acc, q, m} <= '0;
            {is_div, neg_q, neg_r, dz} <= '0;
        end else if (start) begin
            acc    <= '0;
            q      <= (sgn && a[WIDTH-1]) ? -a : a;
            m      <= (sgn && b[WIDTH-1]) ? -b : b;
            is_div <= kind == DIV || kind == DIVU;
            neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= sgn && a[WIDTH-1];
            dz     <= b == '0;
        end else if (step) begin
            acc <= acc_n;
            q   <= q_n;
        end
    end
endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: ALU op decode plus iterative mul/div sequencer owning HI/LO and pipeline stall
module alu_ctrl_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_ctrl_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi, lo, res_hi, res_lo;
    logic [3:0]       op;
    logic             r_type, md_op, mv_op, accept, stall, last, res_vld, mt_hi, mt_lo;
    assign r_type = bus.op_alu == 2'b10;
    assign md_op  = r_type && (bus.funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
    assign mv_op  = r_type && (bus.funct inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO});
    always_comb begin
        op = ALU_ILLEGAL;
        if (bus.op_alu == 2'b00) op = ALU_ADD;
        else if (bus.op_alu == 2'b01) op = ALU_SUB;
        else if (r_type)
            case (bus.funct)
                F_ADD:   op = ALU_ADD;
                F_SUB:   op = ALU_SUB;
                F_AND:   op = ALU_AND;
                F_OR:    op = ALU_OR;
                F_XOR:   op = ALU_XOR;
                F_NOR:   op = ALU_NOR;
                F_SLT:   op = ALU_SLT;
                default: op = (md_op || mv_op) ? ALU_ADD : ALU_ILLEGAL;
            endcase
    end
    assign accept = state != RUN && bus.valid && md_op;
    assign stall  = rst_n && (state == RUN || accept);
    assign last   = cnt == CNT_W'(WIDTH - 1);
    assign mt_hi  = bus.valid && !stall && r_type && bus.funct == F_MTHI;
    assign mt_lo  = bus.valid && !stall && r_type && bus.funct == F_MTLO;
    assign bus.op      = op;
    assign bus.illegal = op == ALU_ILLEGAL;
    assign bus.stall   = stall;
    assign bus.md_rd   = bus.funct == F_MFLO ? lo : hi;
    assign bus.hi      = hi;
    assign bus.lo      = lo;
    assign bus.md_done = state == DONE;
    muldiv_iter #(.WIDTH(WIDTH)) u_md (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept),
        .step    (state == RUN),
        .last    (last),
        .kind    (md_kind_t'(bus.funct[1:0])),
        .a       (bus.rs_val),
        .b       (bus.rt_val),
        .res_hi  (res_hi),
        .res_lo  (res_lo),
        .res_vld (res_vld)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (accept) begin
                state <= RUN;
                cnt   <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                if (last) state <= DONE;
            end else state <= IDLE;
            if (res_vld) {hi, lo} <= {res_hi, res_lo};
            else if (mt_hi) hi <= bus.rs_val;
            else if (mt_lo) lo <= bus.rs_val;
        end
    end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: decode vector table, directed mul/div corner cases and randomized HI/LO scoreboard
module tb_alu_ctrl_seq;
    localparam int W = 32;
    localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
    localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
    typedef struct packed {
        logic [1:0] op_alu;
        logic [5:0] funct;
        logic [3:0] op;
        logic       ill;
    } dvec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    alu_ctrl_seq_if #(.WIDTH(W)) bus();
    alu_ctrl_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.valid  = v;
        bus.op_alu = 2'b10;
        bus.funct  = f;
        bus.rs_val = a;
        bus.rt_val = b;
    endtask

    // {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'(a);
        longint ub = longint'(b);
        if (f == MULT) return 64'(sa * sb);
        if (f == MULTU) return 64'(ua * ub);
        if (b == '0) return {a, {W{1'b1}}};
        if (f == DIV) return {32'(sa % sb), 32'(sa / sb)};
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction

    task automatic run_md(input string nm, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] exp;
        int n;
        exp = ref_md(f, a, b);
        n = 0;
        drive(1'b1, f, a, b);
        #1;
        while (bus.stall && n < 100) begin
            n++;
            tick();
            bus.valid = 1'b0;
            #1;
        end
        chk({nm, " stall cycles"}, 64'(n), 64'(W + 1));
        chk({nm, " md_done"}, 64'(bus.md_done), 64'd1);
        chk({nm, " hi:lo"}, {bus.hi, bus.lo}, exp);
        {m_hi, m_lo} = exp;
    endtask

    initial begin
        dvec_t dv [20];
        logic [63:0] exp;
        int n, k;
        logic [5:0] f;
        logic [W-1:0] a, b;
        dv[0]  = '{2'b00, 6'b111111, 4'b0010, 1'b0};
        dv[1]  = '{2'b01, 6'b000000, 4'b0110, 1'b0};
        dv[2]  = '{2'b10, 6'b100000, 4'b0010, 1'b0};
        dv[3]  = '{2'b10, 6'b100010, 4'b0110, 1'b0};
        dv[4]  = '{2'b10, 6'b100100, 4'b0000, 1'b0};
        dv[5]  = '{2'b10, 6'b100101, 4'b0001, 1'b0};
        dv[6]  = '{2'b10, 6'b100110, 4'b0011, 1'b0};
        dv[7]  = '{2'b10, 6'b100111, 4'b1100, 1'b0};
        dv[8]  = '{2'b10, 6'b101010, 4'b0111, 1'b0};
        dv[9]  = '{2'b10, 6'b011000, 4'b0010, 1'b0};
        dv[10] = '{2'b10, 6'b011001, 4'b0010, 1'b0};
        dv[11] = '{2'b10, 6'b011010, 4'b0010, 1'b0};
        dv[12] = '{2'b10, 6'b011011, 4'b0010, 1'b0};
        dv[13] = '{2'b10, 6'b010000, 4'b0010, 1'b0};
        dv[14] = '{2'b10, 6'b010001, 4'b0010, 1'b0};
        dv[15] = '{2'b10, 6'b010010, 4'b0010, 1'b0};
        dv[16] = '{2'b10, 6'b010011, 4'b0010, 1'b0};
        dv[17] = '{2'b10, 6'b101111, 4'b1111, 1'b1};
        dv[18] = '{2'b11, 6'b100000, 4'b1111, 1'b1};
        dv[19] = '{2'b10, 6'b000000, 4'b1111, 1'b1};
        // reset state, with a mult pending to prove stall is gated by reset
        drive(1'b1, MULT, 32'd3, 32'd4);
        #2;
        chk("rst stall", 64'(bus.stall), 64'd0);
        chk("rst hi", 64'(bus.hi), 64'd0);
        chk("rst lo", 64'(bus.lo), 64'd0);
        chk("rst md_done", 64'(bus.md_done), 64'd0);
        chk("rst op", 64'(bus.op), 64'h2);
        bus.valid = 1'b0;
        #10 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            bus.op_alu = dv[i].op_alu;
            bus.funct  = dv[i].funct;
            #1;
            chk($sformatf("decode[%0d] op", i), 64'(bus.op), 64'(dv[i].op));
            chk($sformatf("decode[%0d] illegal", i), 64'(bus.illegal), 64'(dv[i].ill));
        end
        tick();
        run_md("mult", MULT, 32'd7, 32'hFFFF_FFFD);
        chk("mult hi", 64'(bus.hi), 64'hFFFF_FFFF);
        chk("mult lo", 64'(bus.lo), 64'hFFFF_FFEB);
        // mthi issued in DONE lands at the next edge; md_done must drop
        drive(1'b1, MTHI, 32'hCAFE_0001, '0);
        #1;
        chk("mthi stall", 64'(bus.stall), 64'd0);
        tick();
        bus.valid = 1'b0;
        m_hi = 32'hCAFE_0001;
        #1;
        chk("mthi hi", 64'(bus.hi), 64'(m_hi));
        chk("mthi lo kept", 64'(bus.lo), 64'(m_lo));
        chk("md_done single pulse", 64'(bus.md_done), 64'd0);
        run_md("divu", DIVU, 32'd100, 32'd7);
        chk("divu lo", 64'(bus.lo), 64'd14);
        chk("divu hi", 64'(bus.hi), 64'd2);
        run_md("div", DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div lo", 64'(bus.lo), 64'hFFFF_FFFD);
        chk("div hi", 64'(bus.hi), 64'hFFFF_FFFF);
        run_md("divu0", DIVU, 32'h1234, 32'd0);
        chk("divu0 lo", 64'(bus.lo), 64'hFFFF_FFFF);
        chk("divu0 hi", 64'(bus.hi), 64'h1234);
        run_md("div0 signed", DIV, 32'h8000_0005, 32'd0);
        tick();
        // back-to-back: multu accepted straight out of DONE
        run_md("b2b divu", DIVU, 32'hDEAD_BEEF, 32'd13);
        run_md("b2b multu", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        tick();
        // mflo issued 5 cycles into RUN waits for the new LO
        exp = ref_md(DIVU, 32'd1000, 32'd7);
        drive(1'b1, DIVU, 32'd1000, 32'd7);
        #1;
        chk("hz accept stall", 64'(bus.stall), 64'd1);
        tick();
        bus.valid = 1'b0;
        repeat (4) tick();
        drive(1'b1, MFLO, '0, '0);
        #1;
        n = 0;
        while (bus.stall && n < 100) begin
            n++;
            tick();
            #1;
        end
        chk("hz mflo wait", 64'(n), 64'd28);
        chk("hz md_rd", 64'(bus.md_rd), 64'(exp[W-1:0]));
        chk("hz md_done", 64'(bus.md_done), 64'd1);
        {m_hi, m_lo} = exp;
        tick();
        bus.valid = 1'b0;
        tick();
        // reset at RUN iteration 10 abandons the operation
        drive(1'b1, MULT, 32'd5, 32'd9);
        #1;
        tick();
        bus.valid = 1'b0;
        repeat (9) tick();
        #2;
        rst_n = 1'b0;
        bus.valid = 1'b1;
        #1;
        chk("mid rst stall", 64'(bus.stall), 64'd0);
        chk("mid rst hi", 64'(bus.hi), 64'd0);
        chk("mid rst lo", 64'(bus.lo), 64'd0);
        chk("mid rst md_done", 64'(bus.md_done), 64'd0);
        bus.valid = 1'b0;
        #2 rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        tick();
        chk("post rst stall", 64'(bus.stall), 64'd0);
        run_md("post rst mult", MULT, 32'h0001_2345, 32'hFFFF_0000);
        // randomized traffic against the HI/LO scoreboard
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 7);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            if (k < 4) begin
                f = {4'b0110, 2'(k)};
                run_md($sformatf("rnd[%0d] md", i), f, a, b);
            end else if (k < 6) begin
                f = (k == 4) ? MTHI : MTLO;
                drive(1'b1, f, a, b);
                #1;
                chk($sformatf("rnd[%0d] mt stall", i), 64'(bus.stall), 64'd0);
                tick();
                bus.valid = 1'b0;
                if (k == 4) m_hi = a;
                else m_lo = a;
                #1;
                chk($sformatf("rnd[%0d] mt hi:lo", i), {bus.hi, bus.lo}, {m_hi, m_lo});
            end else begin
                f = (k == 6) ? MFHI : MFLO;
                drive(1'b1, f, a, b);
                #1;
                chk($sformatf("rnd[%0d] md_rd", i), 64'(bus.md_rd), 64'((k == 6) ? m_hi : m_lo));
                tick();
                bus.valid = 1'b0;
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Parametrised successor to the single-cycle ALU control decoder. It keeps the combinational `op_alu`/`funct` → ALU-op decode, adds NOR, XOR and an illegal-op flag, and adds an iterative multiply/divide sequencer with HI/LO registers and a pipeline stall handshake. It sits in the execute stage between the main control unit and the ALU/register-file write-back mux.

## Interface
Parameters:
- `WIDTH`, 32: datapath width. Must be ≥ 4.
- `CNT_W`, `$clog2(WIDTH)`: iteration counter width (derived; not overridden).

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `op_alu` in 2: main-control ALU class. 00 = add, 01 = sub, 10 = R-type, 11 = illegal.
- `funct` in 6: R-type function field.
- `valid` in 1: an instruction is present this cycle.
- `rs_val` in WIDTH: operand A.
- `rt_val` in WIDTH: operand B.
- `op` out 4: ALU operation code.
- `illegal` out 1: unsupported `op_alu`/`funct` combination.
- `stall` out 1: freeze the pipeline this cycle.
- `md_rd` out WIDTH: HI or LO for mfhi/mflo.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `md_done` out 1: one-cycle pulse when a mul/div result lands.

## Operation
ALU decode is combinational and independent of `valid`:
- `op_alu` 00 → 0010. 01 → 0110.
- `op_alu` 10, by `funct`:
  - 100000 → 0010 (ADD)
  - 100010 → 0110 (SUB)
  - 100100 → 0000 (AND)
  - 100101 → 0001 (OR)
  - 100110 → 0011 (XOR)
  - 100111 → 1100 (NOR)
  - 101010 → 0111 (SLT)
  - mul/div/move functs (below) → 0010, with `illegal` = 0
  - any other → 1111, `illegal` = 1
- `op_alu` 11 → 1111, `illegal` = 1.
- No latches: every path assigns `op`.

Mul/div functs, all with `op_alu` = 10:
- 011000 mult, 011001 multu, 011010 div, 011011 divu
- 010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo

Sequencer FSM: IDLE, RUN, DONE.
- **Accept.** In IDLE or DONE, `valid` with a mult/multu/div/divu funct is accepted: latch operands, record signedness, clear the counter, go to RUN.
- **Signed handling.** Signed ops iterate on magnitudes; the result is sign-corrected on write.
  - Product sign = XOR of operand signs.
  - Quotient sign = XOR of operand signs.
  - Remainder sign = dividend sign.
- **RUN.** One iteration per cycle: shift-add multiply, or restoring divide. After iteration WIDTH-1, write `{hi,lo}` = product, or `lo` = quotient and `hi` = remainder, then go to DONE.
- **DONE.** Lasts one cycle. `md_done` = 1. Returns to IDLE unless a new mul/div is accepted, in which case it goes to RUN.
- **Divide by zero.** Still takes WIDTH cycles. Result: `lo` = all ones, `hi` = dividend (unsigned operand, pre-magnitude).
- **mthi/mtlo.** With `valid` and not stalled, write `rs_val` to HI/LO at the edge.
- **mfhi/mflo.** `md_rd` = `hi`/`lo` combinationally.
- **stall** = (state == RUN) OR (state ∈ {IDLE, DONE} AND `valid` AND mul/div funct).
  - While in RUN, new `valid` instructions of any kind are ignored. The pipeline holds them via `stall`.
  - mfhi, mflo, mthi and mtlo issued during RUN therefore wait.

## Timing
- **Reset values.** `rst_n` low asynchronously forces: state IDLE, counter 0, `hi` = 0, `lo` = 0, operand registers 0, `md_done` = 0.
  - Combinational outputs follow their inputs during reset, except that `stall` = 0 while `rst_n` is low.
  - Reset during RUN abandons the operation; HI/LO read 0.
- **Accept at edge E.** `stall` is high in the cycle before E and in the WIDTH cycles of RUN, i.e. WIDTH+1 stall cycles in total.
- **Result write.** HI/LO update at edge E+WIDTH. DONE occupies cycle E+WIDTH to E+WIDTH+1, with `md_done` high and `stall` low.
- **Back-to-back.** A mul/div arriving in DONE is accepted with no IDLE bubble. Its own result overwrites HI/LO WIDTH edges later.
- **mfhi in DONE.** Returns the new result with zero extra wait.
- **Same-cycle mthi/mtlo.** Not possible (single issue). An mthi in DONE writes HI at the next edge.

## Structure
- **Package `alu_pkg`:**
  - ALU op code localparams (AND, OR, ADD, XOR, SUB, SLT, NOR, ILLEGAL)
  - funct localparams
  - state enum {IDLE, RUN, DONE}
  - `md_kind` enum {MULT, MULTU, DIV, DIVU}
- **Sub-module `muldiv_iter`** (WIDTH-parametrised): operand/accumulator registers, one-step shift-add or restore logic, and sign fix-up.
  - Controlled by `start`/`step`/`last` from the FSM in `alu_ctrl_seq`.
  - `alu_ctrl_seq` owns the decode, the FSM, the counter, and the HI/LO registers.

## Test plan
- **R-type sweep.** Every listed funct plus 101111, and `op_alu` 11 → `op` per the decode list; 101111 and `op_alu` 11 give 1111 with `illegal` = 1.
- **mult.** mult 7 × 0xFFFFFFFD (−3), WIDTH = 32 → `stall` for 33 cycles; at E+32 `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB; `md_done` pulses once.
- **divu and div.**
  - divu 100 / 7 → `lo` = 14, `hi` = 2.
  - div 0xFFFFFFF9 (−7) / 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
- **Divide by zero.** divu 0x1234 / 0 → `lo` = 0xFFFFFFFF, `hi` = 0x1234 after 32 cycles.
- **Hazards.**
  - mflo issued 5 cycles into RUN is held by `stall` until DONE, then `md_rd` = the new LO.
  - multu issued in DONE starts with no IDLE cycle.
- **Reset.** Assert `rst_n` low at RUN iteration 10 → immediately IDLE, `stall` = 0, `hi` = `lo` = 0; after release, a fresh mult completes normally.
